// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// ALUOp classes and datapath mux-select codes.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_U,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALUOP_R      = 3'b000;
    localparam logic [2:0] ALUOP_I      = 3'b001;
    localparam logic [2:0] ALUOP_BRANCH = 3'b010;
    localparam logic [2:0] ALUOP_ADD    = 3'b011;
    localparam logic [2:0] ALUOP_UPPER  = 3'b100;
    localparam logic [2:0] ALUOP_JUMP   = 3'b101;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC4    = 2'b10;

    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_RS1  = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    function automatic state_t decode_next(input logic [6:0] opcode);
        case (opcode)
            OP_R:               decode_next = S_EXEC_R;
            OP_I:               decode_next = S_EXEC_I;
            OP_LOAD, OP_STORE:  decode_next = S_MEM_ADDR;
            OP_BRANCH:          decode_next = S_BRANCH;
            OP_JAL:             decode_next = S_JAL;
            OP_JALR:            decode_next = S_JALR;
            OP_LUI, OP_AUIPC:   decode_next = S_EXEC_U;
            default:            decode_next = S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: IR/comparator/memory status in, mux selects,
// write enables and status out. master = controller, slave = datapath.
interface multicycle_control_if #(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
);
    logic [6:0]         Opcode;
    logic               BranchTaken;
    logic               MemReady;
    logic               PCWrite;
    logic               IRWrite;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic [1:0]         MemtoReg;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [ALUOP_W-1:0] ALUOp;
    logic [1:0]         PCSource;
    logic               RegWrite;
    logic               Illegal;
    logic [CNT_W-1:0]   InstrRetired;

    modport master (
        input  Opcode, BranchTaken, MemReady,
        output PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, RegWrite, Illegal, InstrRetired
    );

    modport slave (
        output Opcode, BranchTaken, MemReady,
        input  PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, RegWrite, Illegal, InstrRetired
    );
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Memory-state completion: fixed MEM_LAT-cycle count, or MemReady pass-through when MEM_LAT=0.
// memdone is combinational from the counter (or MemReady); clear restarts the count.
module mem_wait_timer #(
    parameter int MEM_LAT = 1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic MemReady,
    output logic memdone
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'((MEM_LAT >= 1) ? MEM_LAT - 1 : 0);

    logic [CW-1:0] r_cnt;

    // Saturates at LAST so a stall in a non-memory state never wraps.
    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            r_cnt <= '0;
        end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign memdone = (MEM_LAT == 0) ? MemReady : (r_cnt == LAST);
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main control: Moore FSM stepping FETCH/DECODE/EXEC/MEM/WB.
// Memory states stall on mem_wait_timer; illegal opcodes park in TRAP until reset.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32,
    parameter int ALUOP_W = 3
) (
    input  logic                 CLK,
    input  logic                 RESET,
    multicycle_control_if.master bus
);
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_retired;
    logic             r_is_store;
    logic             r_is_lui;

    logic             w_memdone;
    logic             w_clear;
    logic             w_retire;

    logic             w_pc_write;
    logic             w_ir_write;
    logic             w_iord;
    logic             w_mem_read;
    logic             w_mem_write;
    logic [1:0]       w_mem_to_reg;
    logic [1:0]       w_src_a;
    logic [1:0]       w_src_b;
    logic [2:0]       w_aluop;
    logic [1:0]       w_pc_source;
    logic             w_reg_write;
    logic             w_illegal;

    assign w_clear  = (w_next != r_state);
    assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH);

    mem_wait_timer #(.MEM_LAT(MEM_LAT)) u_wait (
        .CLK      (CLK),
        .RESET    (RESET),
        .clear    (w_clear),
        .MemReady (bus.MemReady),
        .memdone  (w_memdone)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_FETCH;
            r_retired  <= '0;
            r_is_store <= 1'b0;
            r_is_lui   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            // Opcode class is captured once; the IR may change afterwards.
            if (r_state == S_DECODE) begin
                r_is_store <= (bus.Opcode == OP_STORE);
                r_is_lui   <= (bus.Opcode == OP_LUI);
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = M2R_ALUOUT;
        w_src_a      = SRCA_PC;
        w_src_b      = SRCB_RS2;
        w_aluop      = ALUOP_R;
        w_pc_source  = PCSRC_ALU;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                w_src_b    = SRCB_FOUR;
                w_aluop    = ALUOP_ADD;
                w_ir_write = w_memdone;
                w_pc_write = w_memdone;
                if (w_memdone) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_src_b = SRCB_IMM;
                w_aluop = ALUOP_ADD;
                w_next  = decode_next(bus.Opcode);
            end
            S_EXEC_R: begin
                w_src_a = SRCA_RS1;
                w_next  = S_WB_ALU;
            end
            S_EXEC_I: begin
                w_src_a = SRCA_RS1;
                w_src_b = SRCB_IMM;
                w_aluop = ALUOP_I;
                w_next  = S_WB_ALU;
            end
            S_EXEC_U: begin
                w_src_a = r_is_lui ? SRCA_ZERO : SRCA_PC;
                w_src_b = SRCB_IMM;
                w_aluop = ALUOP_UPPER;
                w_next  = S_WB_ALU;
            end
            S_WB_ALU: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEM_ADDR: begin
                w_src_a = SRCA_RS1;
                w_src_b = SRCB_IMM;
                w_aluop = ALUOP_ADD;
                w_next  = r_is_store ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                w_iord     = 1'b1;
                w_mem_read = 1'b1;
                if (w_memdone) w_next = S_WB_MEM;
            end
            S_WB_MEM: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = M2R_MDR;
                w_next       = S_FETCH;
            end
            S_MEM_WR: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
                if (w_memdone) w_next = S_FETCH;
            end
            S_BRANCH: begin
                w_src_a     = SRCA_RS1;
                w_aluop     = ALUOP_BRANCH;
                w_pc_source = PCSRC_ALUOUT;
                w_pc_write  = bus.BranchTaken;
                w_next      = S_FETCH;
            end
            S_JAL: begin
                w_pc_write   = 1'b1;
                w_pc_source  = PCSRC_ALUOUT;
                w_reg_write  = 1'b1;
                w_mem_to_reg = M2R_PC4;
                w_next       = S_FETCH;
            end
            S_JALR: begin
                w_src_a      = SRCA_RS1;
                w_src_b      = SRCB_IMM;
                w_aluop      = ALUOP_JUMP;
                w_pc_source  = PCSRC_JALR;
                w_pc_write   = 1'b1;
                w_reg_write  = 1'b1;
                w_mem_to_reg = M2R_PC4;
                w_next       = S_FETCH;
            end
            S_TRAP: begin
                w_illegal = 1'b1;
            end
            default: begin
                w_next = S_TRAP;
            end
        endcase

        // Reset masks every output in the cycle it is asserted: no partial writes.
        if (RESET) begin
            w_pc_write   = 1'b0;
            w_ir_write   = 1'b0;
            w_iord       = 1'b0;
            w_mem_read   = 1'b0;
            w_mem_write  = 1'b0;
            w_mem_to_reg = 2'b00;
            w_src_a      = 2'b00;
            w_src_b      = 2'b00;
            w_aluop      = 3'b000;
            w_pc_source  = 2'b00;
            w_reg_write  = 1'b0;
            w_illegal    = 1'b0;
        end
    end

    assign bus.PCWrite      = w_pc_write;
    assign bus.IRWrite      = w_ir_write;
    assign bus.IorD         = w_iord;
    assign bus.MemRead      = w_mem_read;
    assign bus.MemWrite     = w_mem_write;
    assign bus.MemtoReg     = w_mem_to_reg;
    assign bus.ALUSrcA      = w_src_a;
    assign bus.ALUSrcB      = w_src_b;
    assign bus.ALUOp        = ALUOP_W'(w_aluop);
    assign bus.PCSource     = w_pc_source;
    assign bus.RegWrite     = w_reg_write;
    assign bus.Illegal      = w_illegal;
    assign bus.InstrRetired = RESET ? '0 : r_retired;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: four controller instances (MEM_LAT 1/3/0 and a 4-bit counter)
// stepped cycle by cycle against hand-computed output signatures.
module tb_multicycle_control;

    // Signature: PCW IRW IorD MR MW M2R[2] SA[2] SB[2] OP[3] PCS[2] RW ILL
    localparam logic [17:0] E_ZERO  = 18'b0_0_0_0_0_00_00_00_000_00_0_0;
    localparam logic [17:0] E_FETCH = 18'b1_1_0_1_0_00_00_10_011_00_0_0;
    localparam logic [17:0] E_FWAIT = 18'b0_0_0_1_0_00_00_10_011_00_0_0;
    localparam logic [17:0] E_DEC   = 18'b0_0_0_0_0_00_00_01_011_00_0_0;
    localparam logic [17:0] E_EXR   = 18'b0_0_0_0_0_00_01_00_000_00_0_0;
    localparam logic [17:0] E_EXI   = 18'b0_0_0_0_0_00_01_01_001_00_0_0;
    localparam logic [17:0] E_LUI   = 18'b0_0_0_0_0_00_10_01_100_00_0_0;
    localparam logic [17:0] E_AUIPC = 18'b0_0_0_0_0_00_00_01_100_00_0_0;
    localparam logic [17:0] E_WBA   = 18'b0_0_0_0_0_00_00_00_000_00_1_0;
    localparam logic [17:0] E_MADR  = 18'b0_0_0_0_0_00_01_01_011_00_0_0;
    localparam logic [17:0] E_MRD   = 18'b0_0_1_1_0_00_00_00_000_00_0_0;
    localparam logic [17:0] E_WBM   = 18'b0_0_0_0_0_01_00_00_000_00_1_0;
    localparam logic [17:0] E_MWR   = 18'b0_0_1_0_1_00_00_00_000_00_0_0;
    localparam logic [17:0] E_BRN   = 18'b0_0_0_0_0_00_01_00_010_01_0_0;
    localparam logic [17:0] E_BRT   = 18'b1_0_0_0_0_00_01_00_010_01_0_0;
    localparam logic [17:0] E_JAL   = 18'b1_0_0_0_0_10_00_00_000_01_1_0;
    localparam logic [17:0] E_JALR  = 18'b1_0_0_0_0_10_01_01_101_10_1_0;
    localparam logic [17:0] E_TRAP  = 18'b0_0_0_0_0_00_00_00_000_00_0_1;

    localparam logic [6:0] OPC_ADD   = 7'b0110011;
    localparam logic [6:0] OPC_ADDI  = 7'b0010011;
    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_BAD   = 7'b1111111;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rst_a, rst_b, rst_c, rst_d;
    int   n_chk = 0;
    int   n_err = 0;

    multicycle_control_if #(.ALUOP_W(3), .CNT_W(32)) ifa ();
    multicycle_control_if #(.ALUOP_W(3), .CNT_W(32)) ifb ();
    multicycle_control_if #(.ALUOP_W(3), .CNT_W(32)) ifc ();
    multicycle_control_if #(.ALUOP_W(3), .CNT_W(4))  ifd ();

    multicycle_control #(.MEM_LAT(1), .CNT_W(32), .ALUOP_W(3)) u_a (.CLK(CLK), .RESET(rst_a), .bus(ifa));
    multicycle_control #(.MEM_LAT(3), .CNT_W(32), .ALUOP_W(3)) u_b (.CLK(CLK), .RESET(rst_b), .bus(ifb));
    multicycle_control #(.MEM_LAT(0), .CNT_W(32), .ALUOP_W(3)) u_c (.CLK(CLK), .RESET(rst_c), .bus(ifc));
    multicycle_control #(.MEM_LAT(1), .CNT_W(4),  .ALUOP_W(3)) u_d (.CLK(CLK), .RESET(rst_d), .bus(ifd));

    logic [17:0] sig_a, sig_b, sig_c, sig_d;
    assign sig_a = {ifa.PCWrite, ifa.IRWrite, ifa.IorD, ifa.MemRead, ifa.MemWrite, ifa.MemtoReg,
                    ifa.ALUSrcA, ifa.ALUSrcB, ifa.ALUOp, ifa.PCSource, ifa.RegWrite, ifa.Illegal};
    assign sig_b = {ifb.PCWrite, ifb.IRWrite, ifb.IorD, ifb.MemRead, ifb.MemWrite, ifb.MemtoReg,
                    ifb.ALUSrcA, ifb.ALUSrcB, ifb.ALUOp, ifb.PCSource, ifb.RegWrite, ifb.Illegal};
    assign sig_c = {ifc.PCWrite, ifc.IRWrite, ifc.IorD, ifc.MemRead, ifc.MemWrite, ifc.MemtoReg,
                    ifc.ALUSrcA, ifc.ALUSrcB, ifc.ALUOp, ifc.PCSource, ifc.RegWrite, ifc.Illegal};
    assign sig_d = {ifd.PCWrite, ifd.IRWrite, ifd.IorD, ifd.MemRead, ifd.MemWrite, ifd.MemtoReg,
                    ifd.ALUSrcA, ifd.ALUSrcB, ifd.ALUOp, ifd.PCSource, ifd.RegWrite, ifd.Illegal};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic step_a(input string tag, input logic [17:0] e);
        chk(tag, {14'd0, sig_a}, {14'd0, e});
        tick();
    endtask
    task automatic step_b(input string tag, input logic [17:0] e);
        chk(tag, {14'd0, sig_b}, {14'd0, e});
        tick();
    endtask
    task automatic step_c(input string tag, input logic [17:0] e);
        chk(tag, {14'd0, sig_c}, {14'd0, e});
        tick();
    endtask
    task automatic step_d(input string tag, input logic [17:0] e);
        chk(tag, {14'd0, sig_d}, {14'd0, e});
        tick();
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
        ifa.Opcode = OPC_ADD; ifa.BranchTaken = 1'b0; ifa.MemReady = 1'b0;
        ifb.Opcode = OPC_LW;  ifb.BranchTaken = 1'b0; ifb.MemReady = 1'b0;
        ifc.Opcode = OPC_SW;  ifc.BranchTaken = 1'b0; ifc.MemReady = 1'b0;
        ifd.Opcode = OPC_ADDI; ifd.BranchTaken = 1'b0; ifd.MemReady = 1'b0;
        repeat (3) tick();

        // ---- MEM_LAT=1: one of each class ----
        chk("a_rst_sig", {14'd0, sig_a}, {14'd0, E_ZERO});
        chk("a_rst_ret", ifa.InstrRetired, 32'd0);
        rst_a = 1'b0; #1;
        step_a("add_fetch", E_FETCH); step_a("add_dec", E_DEC); step_a("add_exr", E_EXR);
        chk("add_ret_pre", ifa.InstrRetired, 32'd0);
        step_a("add_wb", E_WBA);
        chk("add_ret", ifa.InstrRetired, 32'd1);

        ifa.Opcode = OPC_ADDI;
        step_a("addi_fetch", E_FETCH); step_a("addi_dec", E_DEC); step_a("addi_exi", E_EXI); step_a("addi_wb", E_WBA);
        chk("addi_ret", ifa.InstrRetired, 32'd2);

        ifa.Opcode = OPC_LUI;
        step_a("lui_fetch", E_FETCH); step_a("lui_dec", E_DEC); step_a("lui_exu", E_LUI); step_a("lui_wb", E_WBA);
        chk("lui_ret", ifa.InstrRetired, 32'd3);

        // AUIPC latched at DECODE; a later switch to LUI must not matter.
        ifa.Opcode = OPC_AUIPC;
        step_a("auipc_fetch", E_FETCH); step_a("auipc_dec", E_DEC);
        ifa.Opcode = OPC_LUI; #1;
        step_a("auipc_exu", E_AUIPC); step_a("auipc_wb", E_WBA);
        chk("auipc_ret", ifa.InstrRetired, 32'd4);

        ifa.Opcode = OPC_BEQ; ifa.BranchTaken = 1'b0;
        step_a("beqn_fetch", E_FETCH); step_a("beqn_dec", E_DEC); step_a("beqn_br", E_BRN);
        chk("beqn_ret", ifa.InstrRetired, 32'd5);
        ifa.BranchTaken = 1'b1; #1;
        step_a("beqt_fetch", E_FETCH); step_a("beqt_dec", E_DEC); step_a("beqt_br", E_BRT);
        chk("beqt_ret", ifa.InstrRetired, 32'd6);
        ifa.BranchTaken = 1'b0;

        ifa.Opcode = OPC_JAL;
        step_a("jal_fetch", E_FETCH); step_a("jal_dec", E_DEC); step_a("jal_ex", E_JAL);
        chk("jal_ret", ifa.InstrRetired, 32'd7);
        ifa.Opcode = OPC_JALR;
        step_a("jalr_fetch", E_FETCH); step_a("jalr_dec", E_DEC); step_a("jalr_ex", E_JALR);
        chk("jalr_ret", ifa.InstrRetired, 32'd8);

        ifa.Opcode = OPC_SW;
        step_a("sw_fetch", E_FETCH); step_a("sw_dec", E_DEC); step_a("sw_addr", E_MADR); step_a("sw_wr", E_MWR);
        chk("sw_ret", ifa.InstrRetired, 32'd9);
        ifa.Opcode = OPC_LW;
        step_a("lw_fetch", E_FETCH); step_a("lw_dec", E_DEC); step_a("lw_addr", E_MADR);
        step_a("lw_rd", E_MRD); step_a("lw_wb", E_WBM);
        chk("lw_ret", ifa.InstrRetired, 32'd10);

        // Illegal opcode: parked in TRAP, counter frozen, only reset leaves.
        ifa.Opcode = OPC_BAD;
        step_a("bad_fetch", E_FETCH); step_a("bad_dec", E_DEC);
        ifa.Opcode = OPC_ADD;
        for (int i = 0; i < 20; i++) step_a("trap_hold", E_TRAP);
        chk("trap_ret", ifa.InstrRetired, 32'd10);
        rst_a = 1'b1; #1;
        chk("trap_rst_sig", {14'd0, sig_a}, {14'd0, E_ZERO});
        tick();
        rst_a = 1'b0; #1;
        chk("trap_rst_ret", ifa.InstrRetired, 32'd0);
        step_a("post_trap_fetch", E_FETCH); step_a("post_trap_dec", E_DEC); step_a("post_trap_exr", E_EXR);
        rst_a = 1'b1;

        // ---- MEM_LAT=3: lw takes 9 cycles ----
        rst_b = 1'b0; #1;
        step_b("b_fetch1", E_FWAIT); step_b("b_fetch2", E_FWAIT); step_b("b_fetch3", E_FETCH);
        step_b("b_dec", E_DEC); step_b("b_addr", E_MADR);
        step_b("b_rd1", E_MRD); step_b("b_rd2", E_MRD); step_b("b_rd3", E_MRD);
        chk("b_ret_pre", ifb.InstrRetired, 32'd0);
        step_b("b_wb", E_WBM);
        chk("b_ret", ifb.InstrRetired, 32'd1);
        step_b("b_next_fetch", E_FWAIT);
        rst_b = 1'b1;

        // ---- MEM_LAT=0: handshake-driven sw ----
        rst_c = 1'b0; #1;
        step_c("c_fetch_wait", E_FWAIT);
        ifc.MemReady = 1'b1; #1;
        step_c("c_fetch_done", E_FETCH);
        ifc.MemReady = 1'b0; #1;
        step_c("c_dec", E_DEC); step_c("c_addr", E_MADR);
        for (int i = 0; i < 4; i++) step_c("c_wr_wait", E_MWR);
        chk("c_ret_pre", ifc.InstrRetired, 32'd0);
        ifc.MemReady = 1'b1; #1;
        step_c("c_wr_done", E_MWR);
        ifc.MemReady = 1'b0; #1;
        chk("c_ret", ifc.InstrRetired, 32'd1);
        step_c("c_next_fetch", E_FWAIT);
        rst_c = 1'b1;

        // ---- CNT_W=4: counter wrap, then reset mid-MEM_RD ----
        rst_d = 1'b0; #1;
        for (int i = 1; i <= 16; i++) begin
            step_d("d_fetch", E_FETCH); step_d("d_dec", E_DEC); step_d("d_exi", E_EXI); step_d("d_wb", E_WBA);
            chk("d_ret", {28'd0, ifd.InstrRetired}, 32'(i % 16));
        end
        ifd.Opcode = OPC_LW;
        step_d("d_lw_fetch", E_FETCH); step_d("d_lw_dec", E_DEC); step_d("d_lw_addr", E_MADR);
        chk("d_lw_rd", {14'd0, sig_d}, {14'd0, E_MRD});
        rst_d = 1'b1; #1;
        chk("d_rst_same", {14'd0, sig_d}, {14'd0, E_ZERO});
        tick();
        chk("d_rst_next", {14'd0, sig_d}, {14'd0, E_ZERO});
        chk("d_rst_ret", {28'd0, ifd.InstrRetired}, 32'd0);
        rst_d = 1'b0; #1;
        step_d("d_after_rst", E_FETCH);
        step_d("d_after_dec", E_DEC);
        rst_d = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Parametrised multi-cycle successor to the single-cycle main decoder for the RV32I core. A registered Moore FSM sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction and drives datapath mux selects and write enables. It waits on memory through a fixed-latency counter or a ready handshake, traps illegal opcodes, and counts retired instructions.

Parameters:
MEM_LAT, 1, cycles per memory state when >=1; 0 selects the MemReady handshake mode
CNT_W, 32, width of the retired-instruction counter
ALUOP_W, 3, ALUOp width; codes 000 R, 001 I, 010 branch, 011 add/address, 100 upper, 101 jump

Ports:
CLK  in  1  clock
RESET  in  1  synchronous active-high reset
Opcode  in  7  instruction[6:0], from the IR
BranchTaken  in  1  comparator result for the current branch
MemReady  in  1  memory done; used only when MEM_LAT=0
PCWrite  out  1  PC write enable
IRWrite  out  1  IR write enable
IorD  out  1  memory address: 0 PC, 1 ALUOut
MemRead  out  1  memory read
MemWrite  out  1  memory write
MemtoReg  out  2  rd source: 00 ALUOut, 01 MDR, 10 PC+4
ALUSrcA  out  2  A operand: 00 PC (OldPC after FETCH), 01 rs1, 10 zero
ALUSrcB  out  2  B operand: 00 rs2, 01 imm, 10 constant 4
ALUOp  out  ALUOP_W  ALU control class
PCSource  out  2  next PC: 00 ALU result, 01 ALUOut, 10 ALU result with LSB cleared
RegWrite  out  1  register-file write enable
Illegal  out  1  sticky illegal-opcode flag
InstrRetired  out  CNT_W  retired-instruction count

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RESET. While RESET=1 the state is forced to FETCH, the wait counter to 0, InstrRetired to 0 and Illegal to 0. All outputs are 0 in that cycle. The first FETCH is the cycle after RESET falls.
- Outputs are combinational from the registered state only (Moore). They never depend on Opcode in the same cycle, except BranchTaken gating PCWrite in BRANCH.
- States: FETCH, DECODE, EXEC_R, EXEC_I, EXEC_U, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, JALR, TRAP.
- memdone: when MEM_LAT>=1, memdone is true in the MEM_LAT-th cycle of the state. When MEM_LAT=0, memdone equals MemReady. The wait counter clears on every state change.
- FETCH: IorD=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, ALUOp=011, PCSource=00. IRWrite and PCWrite are 1 only in the memdone cycle. Go to DECODE on memdone, otherwise hold.
- DECODE: ALUSrcA=00, ALUSrcB=01, ALUOp=011, so ALUOut holds the branch/JAL target. Next state by Opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 or 0010111 -> EXEC_U
  - anything else -> TRAP
- EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=000. Next is WB_ALU.
- EXEC_I: ALUSrcA=01, ALUSrcB=01, ALUOp=001. Next is WB_ALU.
- EXEC_U: ALUSrcB=01, ALUOp=100. ALUSrcA=10 for LUI, 00 for AUIPC, using the latched opcode class. Next is WB_ALU.
- WB_ALU: RegWrite=1, MemtoReg=00. Retires and goes to FETCH.
- MEM_ADDR: ALUSrcA=01, ALUSrcB=01, ALUOp=011. Goes to MEM_RD for loads, MEM_WR for stores.
- MEM_RD: IorD=1, MemRead=1. On memdone goes to WB_MEM.
- WB_MEM: RegWrite=1, MemtoReg=01. Retires and goes to FETCH.
- MEM_WR: IorD=1, MemWrite=1. On memdone it retires and goes to FETCH. MemWrite stays asserted for every wait cycle.
- BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=010, PCSource=01, PCWrite=BranchTaken. Retires and goes to FETCH.
- JAL: PCWrite=1, PCSource=01, RegWrite=1, MemtoReg=10. Retires and goes to FETCH.
- JALR: ALUSrcA=01, ALUSrcB=01, ALUOp=101, PCSource=10, PCWrite=1, RegWrite=1, MemtoReg=10. Retires and goes to FETCH.
- TRAP: Illegal=1 and all enables are 0. The FSM stays in TRAP until RESET.
- Opcode class is latched at DECODE. Opcode changes after DECODE are ignored.
- Cycle counts at MEM_LAT=1: R/I/U/store take 4, load takes 5, branch/JAL/JALR take 3. Each memory state adds MEM_LAT-1 cycles, or the handshake wait when MEM_LAT=0.
- InstrRetired increments by 1 on each transition into FETCH from a retiring state. It wraps modulo 2^CNT_W.
- RESET in any state, including mid-wait or TRAP, takes effect at that clock edge and never produces a partial write.

Decomposition:
- Package multicycle_pkg holds:
  - the state_t enum
  - opcode localparams
  - ALUOp codes
  - the MemtoReg, ALUSrcA, ALUSrcB and PCSource encodings
- Sub-module mem_wait_timer (parameter MEM_LAT) takes CLK, RESET, clear and MemReady, and outputs memdone.

Test Plan:
- MEM_LAT=1, add (0110011) after RESET release -> states FETCH, DECODE, EXEC_R, WB_ALU. RegWrite=1 in cycle 4 only. InstrRetired goes 0 -> 1.
- MEM_LAT=3, lw (0000011) -> FETCH lasts 3 cycles with IRWrite/PCWrite only in the third. MEM_RD lasts 3 cycles with IorD=1. WB_MEM has MemtoReg=01. Total 9 cycles.
- MEM_LAT=0, sw with MemReady low for 4 cycles then high -> MEM_WR holds MemWrite=1 for 5 cycles, then FETCH.
- beq with BranchTaken=0, then with BranchTaken=1 -> PCWrite=0 in BRANCH for the first, PCWrite=1 with PCSource=01 for the second. Each takes 3 cycles.
- Opcode 1111111 -> TRAP with Illegal=1 held for 20 cycles and the counter frozen. RESET clears Illegal and restarts FETCH.
- CNT_W=4, 16 addi instructions -> InstrRetired wraps to 0. RESET asserted mid-MEM_RD -> all outputs 0 on the next cycle and no RegWrite pulse.
